key_debounce: RTL and testbench
===============================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter N_KEYS, default 5, number of independent push-button channels (bit 0 clr_key, 1 start, 2 stopa, 3 stopb, 4 pause).
REQ-002 Parameter DB_CNT, default 500000, consecutive stable cycles required to accept a level change (20 ms at 25 MHz).
REQ-003 Parameter CNT_W, default 20, counter width; DB_CNT SHALL fit in CNT_W bits.
REQ-004 clk  input  1  system clock, 25 MHz board clock; one clock domain, all flops on posedge clk.
REQ-005 clr  input  1  reset, synchronous and active-high.
REQ-006 key_raw  input  N_KEYS  raw, asynchronous, bouncing button levels; 1 = pressed.
REQ-007 key_level  output  N_KEYS  debounced pressed level per key.
REQ-008 key_rise  output  N_KEYS  one-cycle pulse on an accepted press.
REQ-009 key_fall  output  N_KEYS  one-cycle pulse on an accepted release.
REQ-010 key_toggle  output  N_KEYS  level that inverts on every key_rise of that key; used as a latched pause.

Function
REQ-011 Each key_raw bit SHALL pass through a 2-flop synchroniser; its output s is the only value used downstream.
REQ-012 Each key SHALL run an independent 4-state FSM: LOW, PRESS_WAIT, HIGH, RELEASE_WAIT.
REQ-013 LOW: s=1 -> PRESS_WAIT, cnt<=1; else remain, cnt<=0.
REQ-014 PRESS_WAIT: s=0 -> LOW, cnt<=0; s=1 and cnt==DB_CNT-1 -> HIGH, cnt<=0; else cnt<=cnt+1.
REQ-015 HIGH: s=0 -> RELEASE_WAIT, cnt<=1; else remain.
REQ-016 RELEASE_WAIT: s=1 -> HIGH, cnt<=0; s=0 and cnt==DB_CNT-1 -> LOW, cnt<=0; else cnt<=cnt+1.
REQ-017 key_level SHALL be registered and equal 1 exactly while the FSM is in HIGH or RELEASE_WAIT.
REQ-018 key_rise SHALL be high for exactly the one cycle on which key_level goes 0->1; key_fall likewise for 1->0.
REQ-019 Latency from a clean key_raw edge to the key_level edge SHALL be DB_CNT+2 cycles.
REQ-020 A bounce or glitch shorter than DB_CNT consecutive cycles of s SHALL produce no change on any output.
REQ-021 key_toggle SHALL invert on the same edge that key_rise is asserted; key_fall SHALL not affect it.
REQ-022 Keys SHALL be fully independent; simultaneous presses SHALL yield simultaneous pulses, with no priority or masking.
REQ-023 The counter SHALL never exceed DB_CNT-1 and SHALL never wrap.

Reset
REQ-024 While clr=1 at a clock edge: synchronisers, cnt, and FSM state (LOW) SHALL clear; key_level, key_rise, key_fall and key_toggle SHALL be 0 on the next cycle.
REQ-025 A reset asserted mid-count SHALL discard the partial count; no pulse SHALL be emitted for that key.
REQ-026 A key still held when clr deasserts SHALL be accepted as a new press after DB_CNT+2 cycles, producing one key_rise.

Structure
REQ-027 A shared package SHALL hold the FSM state enum (2 bits), CLK_HZ=25000000, and the default DB_CNT.
REQ-028 One sub-module key_db_cell SHALL contain the synchroniser, FSM, counter and output registers for one key; key_debounce SHALL instantiate it N_KEYS times via generate.

Verification (DB_CNT=4 override)
REQ-029 Reset: clr=1 for 2 cycles, key_raw=5'b11111 -> all outputs 0 during reset; key_level=5'b11111 on cycle 6 after release; one key_rise on every bit.
REQ-030 Clean press: key_raw[1] 0->1 at cycle 0 and held -> key_level[1]=1 and key_rise[1]=1 at cycle 6; key_rise[1]=0 at cycle 7.
REQ-031 Bounce: key_raw[2] toggles 1,0,1,1,0, then holds at 1 -> no output change until 6 cycles after the final 0->1 edge; exactly one key_rise[2].
REQ-032 Release and toggle: press/release key 4 twice -> key_fall[4] pulses 6 cycles after each release; key_toggle[4] sequence 0->1->0.
REQ-033 Simultaneous press: key_raw bits 2 and 3 rise on the same cycle -> key_rise[2] and key_rise[3] high together for one cycle.
REQ-034 Mid-count reset: press key 0, assert clr at cycle 3 -> no key_rise[0] before reset release; new rise 6 cycles after clr deasserts.

Source files
------------

// File: rtl/key_debounce_pkg.sv
// Shared definitions for the push-button debouncer: per-key FSM encoding
// and board timing constants.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    ST_LOW          = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HIGH         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } db_state_e;

  localparam int CLK_HZ         = 25000000;
  // 20 ms of stable input at CLK_HZ.
  localparam int DB_CNT_DEFAULT = 500000;
  localparam int CNT_W_DEFAULT  = 20;

endpackage

// File: rtl/key_db_cell.sv
// One debounced key: 2-flop synchroniser, 4-state stability FSM with its
// counter, and registered level / edge-pulse / toggle outputs.
module key_db_cell
  import key_debounce_pkg::*;
#(
  parameter int DB_CNT = DB_CNT_DEFAULT,
  parameter int CNT_W  = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic clr,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic toggle
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1;
  logic             s;
  logic [CNT_W-1:0] cnt;
  db_state_e        state;

  // level/rise/fall/toggle are updated on the same edge as the state change,
  // so level is high exactly while state is HIGH or RELEASE_WAIT.
  always_ff @(posedge clk) begin
    if (clr) begin
      sync1  <= 1'b0;
      s      <= 1'b0;
      cnt    <= '0;
      state  <= ST_LOW;
      level  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
      toggle <= 1'b0;
    end else begin
      sync1 <= raw;
      s     <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      case (state)
        ST_LOW: begin
          if (s) begin
            state <= ST_PRESS_WAIT;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (!s) begin
            state <= ST_LOW;
            cnt   <= '0;
          end else if (cnt >= CNT_LAST) begin
            // >= rather than == keeps the counter from ever running past the limit.
            state  <= ST_HIGH;
            cnt    <= '0;
            level  <= 1'b1;
            rise   <= 1'b1;
            toggle <= ~toggle;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (!s) begin
            state <= ST_RELEASE_WAIT;
            cnt   <= CNT_ONE;
          end
        end
        ST_RELEASE_WAIT: begin
          if (s) begin
            state <= ST_HIGH;
            cnt   <= '0;
          end else if (cnt >= CNT_LAST) begin
            state <= ST_LOW;
            cnt   <= '0;
            level <= 1'b0;
            fall  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= ST_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Bank of N_KEYS independent debounced push-buttons
// (bit 0 clr_key, 1 start, 2 stopa, 3 stopb, 4 pause).
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int N_KEYS = 5,
  parameter int DB_CNT = DB_CNT_DEFAULT,
  parameter int CNT_W  = CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_rise,
  output logic [N_KEYS-1:0] key_fall,
  output logic [N_KEYS-1:0] key_toggle
);

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    key_db_cell #(
      .DB_CNT(DB_CNT),
      .CNT_W (CNT_W)
    ) u_cell (
      .clk   (clk),
      .clr   (clr),
      .raw   (key_raw[g]),
      .level (key_level[g]),
      .rise  (key_rise[g]),
      .fall  (key_fall[g]),
      .toggle(key_toggle[g])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Table-driven bench for key_debounce with DB_CNT=4: each record is one
// clock of inputs plus the outputs expected right after that clock edge.
module tb_key_debounce;

  localparam int N  = 5;
  localparam int DB = 4;

  logic         clk = 1'b0;
  logic         clr;
  logic [N-1:0] key_raw;
  logic [N-1:0] key_level;
  logic [N-1:0] key_rise;
  logic [N-1:0] key_fall;
  logic [N-1:0] key_toggle;

  key_debounce #(
    .N_KEYS(N),
    .DB_CNT(DB),
    .CNT_W (3)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .key_raw   (key_raw),
    .key_level (key_level),
    .key_rise  (key_rise),
    .key_fall  (key_fall),
    .key_toggle(key_toggle)
  );

  // clock
  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    logic         clr;
    logic [N-1:0] raw;
    logic [N-1:0] lvl;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] tog;
  } vec_t;

  vec_t           vecs[$];
  logic [4*N-1:0] exp_q[$];
  int             n_checks = 0;
  int             n_fail   = 0;

  function automatic void add(string tag, int n, logic c, logic [N-1:0] r,
                              logic [N-1:0] l, logic [N-1:0] ri,
                              logic [N-1:0] f, logic [N-1:0] t);
    for (int k = 0; k < n; k++) vecs.push_back('{tag, c, r, l, ri, f, t});
  endfunction

  task automatic apply_vec(input int idx);
    logic [4*N-1:0] got;
    logic [4*N-1:0] exp;
    clr     = vecs[idx].clr;
    key_raw = vecs[idx].raw;
    exp_q.push_back({vecs[idx].lvl, vecs[idx].rise, vecs[idx].fall, vecs[idx].tog});
    @(posedge clk);
    #2;
    got = {key_level, key_rise, key_fall, key_toggle};
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] level/rise/fall/toggle got %h/%h/%h/%h exp %h/%h/%h/%h",
               vecs[idx].tag, idx, got[19:15], got[14:10], got[9:5], got[4:0],
               exp[19:15], exp[14:10], exp[9:5], exp[4:0]);
    end
  endtask

  initial begin
    clr     = 1'b1;
    key_raw = '0;

    // reset with every key held, release, then all keys released
    add("rst_hold",      2, 1, 5'h1F, 5'h00, 5'h00, 5'h00, 5'h00);
    add("rst_rel_wait",  5, 0, 5'h1F, 5'h00, 5'h00, 5'h00, 5'h00);
    add("rst_rel_rise",  1, 0, 5'h1F, 5'h1F, 5'h1F, 5'h00, 5'h1F);
    add("rst_rel_held",  2, 0, 5'h1F, 5'h1F, 5'h00, 5'h00, 5'h1F);
    add("all_rel_wait",  5, 0, 5'h00, 5'h1F, 5'h00, 5'h00, 5'h1F);
    add("all_rel_fall",  1, 0, 5'h00, 5'h00, 5'h00, 5'h1F, 5'h1F);
    add("all_rel_idle",  2, 0, 5'h00, 5'h00, 5'h00, 5'h00, 5'h1F);
    add("rst2",          2, 1, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
    add("idle2",         2, 0, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);

    // clean press/release of key 1
    add("k1_wait",       5, 0, 5'h02, 5'h00, 5'h00, 5'h00, 5'h00);
    add("k1_rise",       1, 0, 5'h02, 5'h02, 5'h02, 5'h00, 5'h02);
    add("k1_held",       2, 0, 5'h02, 5'h02, 5'h00, 5'h00, 5'h02);
    add("k1_rel_wait",   5, 0, 5'h00, 5'h02, 5'h00, 5'h00, 5'h02);
    add("k1_fall",       1, 0, 5'h00, 5'h00, 5'h00, 5'h02, 5'h02);
    add("k1_idle",       2, 0, 5'h00, 5'h00, 5'h00, 5'h00, 5'h02);

    // key 2 bounces 1,0,1,1,0 then settles high; later a 2-cycle release glitch
    add("k2_bounce",     1, 0, 5'h04, 5'h00, 5'h00, 5'h00, 5'h02);
    add("k2_bounce",     1, 0, 5'h00, 5'h00, 5'h00, 5'h00, 5'h02);
    add("k2_bounce",     2, 0, 5'h04, 5'h00, 5'h00, 5'h00, 5'h02);
    add("k2_bounce",     1, 0, 5'h00, 5'h00, 5'h00, 5'h00, 5'h02);
    add("k2_wait",       5, 0, 5'h04, 5'h00, 5'h00, 5'h00, 5'h02);
    add("k2_rise",       1, 0, 5'h04, 5'h04, 5'h04, 5'h00, 5'h06);
    add("k2_held",       2, 0, 5'h04, 5'h04, 5'h00, 5'h00, 5'h06);
    add("k2_glitch",     2, 0, 5'h00, 5'h04, 5'h00, 5'h00, 5'h06);
    add("k2_glitch_end", 4, 0, 5'h04, 5'h04, 5'h00, 5'h00, 5'h06);
    add("k2_rel_wait",   5, 0, 5'h00, 5'h04, 5'h00, 5'h00, 5'h06);
    add("k2_fall",       1, 0, 5'h00, 5'h00, 5'h00, 5'h04, 5'h06);
    add("k2_idle",       2, 0, 5'h00, 5'h00, 5'h00, 5'h00, 5'h06);

    // keys 2 and 3 pressed on the same cycle
    add("k23_wait",      5, 0, 5'h0C, 5'h00, 5'h00, 5'h00, 5'h06);
    add("k23_rise",      1, 0, 5'h0C, 5'h0C, 5'h0C, 5'h00, 5'h0A);
    add("k23_held",      2, 0, 5'h0C, 5'h0C, 5'h00, 5'h00, 5'h0A);
    add("k23_rel_wait",  5, 0, 5'h00, 5'h0C, 5'h00, 5'h00, 5'h0A);
    add("k23_fall",      1, 0, 5'h00, 5'h00, 5'h00, 5'h0C, 5'h0A);
    add("k23_idle",      2, 0, 5'h00, 5'h00, 5'h00, 5'h00, 5'h0A);

    // reset, then press/release key 4 twice: toggle goes 0 -> 1 -> 0
    add("rst3",          2, 1, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
    add("idle3",         2, 0, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
    add("k4a_wait",      5, 0, 5'h10, 5'h00, 5'h00, 5'h00, 5'h00);
    add("k4a_rise",      1, 0, 5'h10, 5'h10, 5'h10, 5'h00, 5'h10);
    add("k4a_held",      2, 0, 5'h10, 5'h10, 5'h00, 5'h00, 5'h10);
    add("k4a_rel_wait",  5, 0, 5'h00, 5'h10, 5'h00, 5'h00, 5'h10);
    add("k4a_fall",      1, 0, 5'h00, 5'h00, 5'h00, 5'h10, 5'h10);
    add("k4a_idle",      2, 0, 5'h00, 5'h00, 5'h00, 5'h00, 5'h10);
    add("k4b_wait",      5, 0, 5'h10, 5'h00, 5'h00, 5'h00, 5'h10);
    add("k4b_rise",      1, 0, 5'h10, 5'h10, 5'h10, 5'h00, 5'h00);
    add("k4b_held",      2, 0, 5'h10, 5'h10, 5'h00, 5'h00, 5'h00);
    add("k4b_rel_wait",  5, 0, 5'h00, 5'h10, 5'h00, 5'h00, 5'h00);
    add("k4b_fall",      1, 0, 5'h00, 5'h00, 5'h00, 5'h10, 5'h00);
    add("k4b_idle",      2, 0, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);

    // key 0 pressed, reset lands mid-count, key still held after release
    add("k0_pre",        3, 0, 5'h01, 5'h00, 5'h00, 5'h00, 5'h00);
    add("k0_clr",        2, 1, 5'h01, 5'h00, 5'h00, 5'h00, 5'h00);
    add("k0_rel_wait",   5, 0, 5'h01, 5'h00, 5'h00, 5'h00, 5'h00);
    add("k0_rise",       1, 0, 5'h01, 5'h01, 5'h01, 5'h00, 5'h01);
    add("k0_held",       2, 0, 5'h01, 5'h01, 5'h00, 5'h00, 5'h01);

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) apply_vec(i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
